// File: rtl/arima_result_writer.sv
// Result writer for the ARIMA anomaly core: buffers (prediction, label, address) tuples in a
// show-ahead FIFO, drains them over a valid/ready write port and tracks anomaly statistics.
module arima_result_writer #(
  parameter int N       = 32,
  parameter int AW      = 32,
  parameter int DEPTH   = 8,
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  input  logic [AW-1:0]    in_addr,
  input  logic             in_label,
  input  logic             clear,
  output logic             out_wren,
  output logic [N-1:0]     out_data,
  output logic [AW-1:0]    out_addr,
  output logic             out_label,
  input  logic             out_ready,
  output logic [CNT_W-1:0] anomaly_count,
  output logic             alarm,
  output logic             drop,
  output logic             fifo_full,
  output logic             fifo_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int RW = $clog2(RUN_LEN + 1);
  localparam int EW = 1 + AW + N;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [RW-1:0]    RUN_MAX = RW'(RUN_LEN);

  typedef enum logic {
    S_EMPTY,
    S_HOLD
  } state_t;

  state_t           state, state_nxt;
  logic [EW-1:0]    mem [DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr, count;
  logic [PW:0]      wr_ptr_nxt, rd_ptr_nxt, count_nxt, count_after_pop;
  logic             push, pop;
  logic             load_head;
  logic [EW-1:0]    head_nxt;
  logic [EW-1:0]    in_entry;

  logic [RW-1:0]    run, run_nxt;
  logic [CNT_W-1:0] anomaly_count_nxt;
  logic             alarm_nxt, drop_nxt;

  assign fifo_full  = (count == (PW+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = out_wren & out_ready;
  assign push       = in_valid & (~fifo_full | pop);
  assign in_entry   = {in_label, in_addr, in_data};

  // Pointer and occupancy bookkeeping; the wrap bit disambiguates full from empty.
  always_comb begin
    wr_ptr_nxt      = wr_ptr + (PW+1)'(push);
    rd_ptr_nxt      = rd_ptr + (PW+1)'(pop);
    count_after_pop = count - (PW+1)'(pop);
    count_nxt       = count_after_pop + (PW+1)'(push);
  end

  // Output-register state machine; the head is reloaded on every pop and on a push into empty.
  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    unique case (state)
      S_EMPTY: begin
        if (push) begin
          state_nxt = S_HOLD;
          load_head = 1'b1;
        end
      end
      S_HOLD: begin
        if (pop) begin
          load_head = 1'b1;
          if (count_after_pop == '0 && !push) state_nxt = S_EMPTY;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // When nothing older survives the pop, the incoming sample becomes the head directly.
  always_comb begin
    head_nxt = '0;
    if (count_after_pop != '0) head_nxt = mem[rd_ptr_nxt[PW-1:0]];
    else if (push)             head_nxt = in_entry;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= in_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_EMPTY;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_label <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (load_head) {out_label, out_addr, out_data} <= head_nxt;
    end
  end

  assign out_wren = (state == S_HOLD);

  // Statistics: clear acts first, then an accepted push in the same cycle is folded in.
  always_comb begin
    anomaly_count_nxt = clear ? '0 : anomaly_count;
    run_nxt           = clear ? '0 : run;
    alarm_nxt         = clear ? 1'b0 : alarm;
    drop_nxt          = clear ? 1'b0 : drop;
    if (push) begin
      if (in_label) begin
        if (anomaly_count_nxt != CNT_MAX) anomaly_count_nxt = anomaly_count_nxt + 1'b1;
        if (run_nxt != RUN_MAX)           run_nxt = run_nxt + 1'b1;
        if (run_nxt == RUN_MAX)           alarm_nxt = 1'b1;
      end else begin
        run_nxt = '0;
      end
    end
    if (in_valid && fifo_full && !pop) drop_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      anomaly_count <= '0;
      run           <= '0;
      alarm         <= 1'b0;
      drop          <= 1'b0;
    end else begin
      anomaly_count <= anomaly_count_nxt;
      run           <= run_nxt;
      alarm         <= alarm_nxt;
      drop          <= drop_nxt;
    end
  end

endmodule
